// File: rtl/jt8255_fifo.sv
// jt8255_fifo: parametrised 8255-style parallel port block.
// NP ports of DW bits; each port runs simple latched I/O (mode 0),
// strobed input (mode 1) or strobed output (mode 2) through a 2**FAW FIFO.
// CPU handshake: a write is taken when the write strobe is released
// (registered write 1 -> 0), using the address/data captured while it was
// asserted; a read updates dout every cycle it is asserted and pops the
// FIFO when it is released.
module jt8255_fifo #(
    parameter int DW  = 8,
    parameter int NP  = 2,
    parameter int FAW = 2
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [3:0]       addr,
    input  logic [DW-1:0]    din,
    output logic [DW-1:0]    dout,
    input  logic             rdn,
    input  logic             wrn,
    input  logic             csn,
    input  logic [NP*DW-1:0] port_din,
    output logic [NP*DW-1:0] port_dout,
    output logic [NP*DW-1:0] port_oe,
    input  logic [NP-1:0]    stbn,
    input  logic [NP-1:0]    ackn,
    output logic [NP-1:0]    ibf,
    output logic [NP-1:0]    obfn,
    output logic             intn
);
    localparam int D  = 1 << FAW;
    localparam int CW = FAW + 1;

    logic          rd, wr, rd_q, wr_q, wr_commit, rd_fall;
    logic [3:0]    addr_w, addr_r;
    logic [DW-1:0] din_w, rd_data;

    // per-port registers
    logic [DW-1:0]  dir   [NP];
    logic [DW-1:0]  latch [NP];
    logic [DW-1:0]  hold  [NP];
    logic [1:0]     mode  [NP];
    logic [FAW-1:0] rptr  [NP];
    logic [FAW-1:0] wptr  [NP];
    logic [CW-1:0]  cnt   [NP];
    logic [DW-1:0]  mem   [NP][D];
    logic [NP-1:0]  inte, ovf, stb_q, ack_q;

    // per-port decoded control
    logic [DW-1:0]  head  [NP];
    logic [NP-1:0]  m1, m2, empty, full, push, pop, do_push;
    logic [NP-1:0]  sel_data, sel_dir, sel_ctrl, sel_stat, sel_pop;
    logic [NP-1:0]  fifo_clr, ovf_clr, intr;

    assign rd        = ~rdn & ~csn;
    assign wr        = ~wrn & ~csn;
    assign wr_commit = wr_q & ~wr;
    assign rd_fall   = rd_q & ~rd;

    for (genvar p = 0; p < NP; p++) begin : g_port
        assign m1[p]    = (mode[p] == 2'd1);
        assign m2[p]    = (mode[p] == 2'd2);
        assign empty[p] = (cnt[p] == '0);
        assign full[p]  = (cnt[p] == CW'(D));
        assign head[p]  = mem[p][rptr[p]];

        assign sel_data[p] = wr_commit && (addr_w == {2'(p), 2'd0});
        assign sel_dir[p]  = wr_commit && (addr_w == {2'(p), 2'd1});
        assign sel_ctrl[p] = wr_commit && (addr_w == {2'(p), 2'd2});
        assign sel_stat[p] = wr_commit && (addr_w == {2'(p), 2'd3});
        assign sel_pop[p]  = rd_fall   && (addr_r == {2'(p), 2'd0});

        // pop is gated by !empty, so push+pop on an empty FIFO is push only
        assign push[p]    = m1[p] ? (stb_q[p] & ~stbn[p]) : (m2[p] & sel_data[p]);
        assign pop[p]     = ~empty[p] & (m1[p] ? sel_pop[p] : (m2[p] & ack_q[p] & ~ackn[p]));
        assign do_push[p] = push[p] & (~full[p] | pop[p]);
        assign fifo_clr[p] = sel_ctrl[p] & ((din_w[1:0] != mode[p]) | din_w[3]);
        assign ovf_clr[p]  = fifo_clr[p] | sel_stat[p];
        assign intr[p]     = inte[p] & (m1[p] ? ~empty[p] : (m2[p] & ~full[p]));

        assign port_dout[p*DW +: DW] = m2[p] ? (empty[p] ? hold[p] : head[p]) : latch[p];
        assign port_oe[p*DW +: DW]   = m1[p] ? '0 : (m2[p] ? '1 : ~dir[p]);
        assign ibf[p]  = m1[p] & ~empty[p];
        assign obfn[p] = ~(m2[p] & ~empty[p]);
    end

    // CPU read multiplexer; unmapped ports read as all ones
    always_comb begin
        rd_data = '1;
        for (int p = 0; p < NP; p++) begin
            if (addr[3:2] == 2'(p)) begin
                case (addr[1:0])
                    2'd0: begin
                        if (m1[p])      rd_data = empty[p] ? '1 : head[p];
                        else if (m2[p]) rd_data = port_dout[p*DW +: DW];
                        else rd_data = (dir[p] & port_din[p*DW +: DW]) | (~dir[p] & latch[p]);
                    end
                    2'd1: rd_data = dir[p];
                    2'd2: begin
                        rd_data      = '0;
                        rd_data[1:0] = mode[p];
                        rd_data[2]   = inte[p];
                    end
                    default: begin
                        rd_data      = '0;
                        rd_data[0]   = empty[p];
                        rd_data[1]   = full[p];
                        rd_data[2]   = ovf[p];
                        rd_data[3]   = inte[p];
                        rd_data[7:4] = 4'(cnt[p]);
                    end
                endcase
            end
        end
    end

    // bus edge tracking, register file, FIFO pointers and interrupt
    always_ff @(posedge clk) begin
        if (!rstn) begin
            rd_q   <= 1'b0;
            wr_q   <= 1'b0;
            addr_w <= '0;
            addr_r <= '0;
            din_w  <= '0;
            dout   <= '1;
            intn   <= 1'b1;
            stb_q  <= '1;
            ack_q  <= '1;
            inte   <= '0;
            ovf    <= '0;
            for (int p = 0; p < NP; p++) begin
                dir[p]   <= '1;
                latch[p] <= '1;
                hold[p]  <= '1;
                mode[p]  <= 2'd0;
                rptr[p]  <= '0;
                wptr[p]  <= '0;
                cnt[p]   <= '0;
            end
        end else begin
            rd_q  <= rd;
            wr_q  <= wr;
            stb_q <= stbn;
            ack_q <= ackn;
            intn  <= ~|intr;
            if (wr) begin
                addr_w <= addr;
                din_w  <= din;
            end
            if (rd) begin
                addr_r <= addr;
                dout   <= rd_data;
            end
            for (int p = 0; p < NP; p++) begin
                if (sel_data[p] && !m2[p]) latch[p] <= din_w;
                if (sel_dir[p])            dir[p]   <= din_w;
                if (sel_ctrl[p]) begin
                    mode[p] <= din_w[1:0];
                    inte[p] <= din_w[2];
                end
                if (fifo_clr[p]) begin
                    rptr[p] <= '0;
                    wptr[p] <= '0;
                    cnt[p]  <= '0;
                end else begin
                    if (do_push[p]) wptr[p] <= wptr[p] + FAW'(1);
                    if (pop[p]) begin
                        rptr[p] <= rptr[p] + FAW'(1);
                        hold[p] <= head[p];
                    end
                    cnt[p] <= cnt[p] + CW'(do_push[p]) - CW'(pop[p]);
                end
                if (ovf_clr[p])                 ovf[p] <= 1'b0;
                else if (push[p] && !do_push[p]) ovf[p] <= 1'b1;
            end
        end
    end

    // FIFO storage: strobed-in ports take pin data, strobed-out ports take CPU data
    always_ff @(posedge clk) begin
        for (int p = 0; p < NP; p++) begin
            if (rstn && do_push[p] && !fifo_clr[p])
                mem[p][wptr[p]] <= m1[p] ? port_din[p*DW +: DW] : din_w;
        end
    end
endmodule

// File: tb/tb_jt8255_fifo.sv
// Directed bench for jt8255_fifo (DW=8, NP=2, FAW=2).
module tb_jt8255_fifo;
    logic        clk = 1'b0;
    logic        rstn;
    logic [3:0]  addr;
    logic [7:0]  din, dout;
    logic        rdn, wrn, csn;
    logic [15:0] port_din, port_dout, port_oe;
    logic [1:0]  stbn, ackn, ibf, obfn;
    logic        intn;

    int n_checks = 0;
    int n_err    = 0;
    logic [7:0] r;

    jt8255_fifo #(.DW(8), .NP(2), .FAW(2)) dut (
        .clk(clk), .rstn(rstn), .addr(addr), .din(din), .dout(dout),
        .rdn(rdn), .wrn(wrn), .csn(csn), .port_din(port_din),
        .port_dout(port_dout), .port_oe(port_oe), .stbn(stbn), .ackn(ackn),
        .ibf(ibf), .obfn(obfn), .intn(intn)
    );

    // clock
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_wr(input logic [3:0] a, input logic [7:0] d);
        tick;
        addr = a; din = d; csn = 1'b0; wrn = 1'b0;
        tick;
        wrn = 1'b1; csn = 1'b1;
        tick;
    endtask

    task automatic cpu_rd(input logic [3:0] a, output logic [7:0] d);
        tick;
        addr = a; csn = 1'b0; rdn = 1'b0;
        tick;
        d = dout;
        rdn = 1'b1; csn = 1'b1;
        tick;
    endtask

    task automatic stb_pulse(input int p, input logic [7:0] v);
        tick;
        port_din[p*8 +: 8] = v;
        stbn[p] = 1'b0;
        tick;
        stbn[p] = 1'b1;
        tick;
    endtask

    task automatic ack_pulse(input int p);
        tick;
        ackn[p] = 1'b0;
        tick;
        ackn[p] = 1'b1;
        tick;
    endtask

    initial begin
        rstn = 1'b0; addr = '0; din = '0; rdn = 1'b1; wrn = 1'b1; csn = 1'b1;
        port_din = '0; stbn = '1; ackn = '1;
        repeat (3) tick;
        rstn = 1'b1;
        tick;

        // reset state
        check("rst_dout", dout, 8'hFF);
        check("rst_port_dout", port_dout, 16'hFFFF);
        check("rst_port_oe", port_oe, 16'h0000);
        check("rst_obfn", obfn, 2'b11);
        check("rst_ibf", ibf, 2'b00);
        check("rst_intn", intn, 1'b1);
        cpu_rd(4'h3, r); check("rst_stat0", r, 8'h01);

        // mode 0 simple I/O
        cpu_wr(4'h1, 8'hF0);
        cpu_wr(4'h0, 8'h5A);
        port_din[7:0] = 8'h3C;
        tick;
        check("m0_oe", port_oe[7:0], 8'h0F);
        check("m0_dout", port_dout[7:0], 8'h5A);
        cpu_rd(4'h0, r); check("m0_read", r, 8'h3A);
        cpu_rd(4'h1, r); check("m0_dir", r, 8'hF0);
        cpu_wr(4'h5, 8'h00);
        cpu_wr(4'h4, 8'hC3);
        check("p1_oe", port_oe[15:8], 8'hFF);
        check("p1_dout", port_dout[15:8], 8'hC3);
        cpu_wr(4'h9, 8'h00);
        check("oor_write", port_oe, 16'hFF0F);
        cpu_rd(4'h8, r); check("oor_read", r, 8'hFF);

        // mode 1 strobed input with overflow
        cpu_wr(4'h2, 8'h05);
        check("m1_oe", port_oe[7:0], 8'h00);
        check("m1_ibf_empty", ibf[0], 1'b0);
        for (int i = 1; i <= 5; i++) stb_pulse(0, 8'(i));
        check("m1_ibf", ibf[0], 1'b1);
        check("m1_intn", intn, 1'b0);
        cpu_rd(4'h3, r); check("m1_stat_full", r, 8'h4E);
        for (int i = 1; i <= 4; i++) begin
            cpu_rd(4'h0, r); check("m1_pop", r, 8'(i));
        end
        cpu_rd(4'h0, r); check("m1_empty_read", r, 8'hFF);
        tick;
        check("m1_intn_idle", intn, 1'b1);
        cpu_rd(4'h3, r); check("m1_stat_ovf", r, 8'h0D);
        cpu_wr(4'h3, 8'h00);
        cpu_rd(4'h3, r); check("m1_stat_ovf_clr", r, 8'h09);

        // mode 2 strobed output
        cpu_wr(4'h2, 8'h02);
        check("m2_oe", port_oe[7:0], 8'hFF);
        check("m2_obfn_empty", obfn[0], 1'b1);
        cpu_wr(4'h0, 8'hA1);
        cpu_wr(4'h0, 8'hB2);
        check("m2_head", port_dout[7:0], 8'hA1);
        check("m2_obfn", obfn[0], 1'b0);
        ack_pulse(0);
        check("m2_ack1", port_dout[7:0], 8'hB2);
        ack_pulse(0);
        check("m2_obfn_drained", obfn[0], 1'b1);
        check("m2_hold", port_dout[7:0], 8'hB2);

        // mode 2 full: simultaneous push and pop
        cpu_wr(4'h2, 8'h06);
        tick;
        check("m2_intn_notfull", intn, 1'b0);
        cpu_wr(4'h0, 8'h11);
        cpu_wr(4'h0, 8'h22);
        cpu_wr(4'h0, 8'h33);
        cpu_wr(4'h0, 8'h44);
        tick;
        check("m2_intn_full", intn, 1'b1);
        cpu_rd(4'h3, r); check("m2_stat_full", r, 8'h4A);
        tick;
        addr = 4'h0; din = 8'h55; csn = 1'b0; wrn = 1'b0;
        tick;
        wrn = 1'b1; csn = 1'b1; ackn[0] = 1'b0;
        tick;
        ackn[0] = 1'b1;
        tick;
        cpu_rd(4'h3, r); check("m2_stat_same", r, 8'h4A);
        check("m2_order0", port_dout[7:0], 8'h22);
        ack_pulse(0); check("m2_order1", port_dout[7:0], 8'h33);
        ack_pulse(0); check("m2_order2", port_dout[7:0], 8'h44);
        ack_pulse(0); check("m2_order3", port_dout[7:0], 8'h55);
        ack_pulse(0); check("m2_last_obfn", obfn[0], 1'b1);
        ack_pulse(0); check("m2_last_hold", port_dout[7:0], 8'h55);

        // clear bit, then reset mid-transfer
        cpu_wr(4'h2, 8'h05);
        stb_pulse(0, 8'h07);
        stb_pulse(0, 8'h08);
        stb_pulse(0, 8'h09);
        cpu_rd(4'h3, r); check("m1_stat3", r, 8'h38);
        cpu_wr(4'h2, 8'h0D);
        cpu_rd(4'h3, r); check("clr_stat", r, 8'h09);
        cpu_rd(4'h2, r); check("clr_ctrl", r, 8'h05);
        stb_pulse(0, 8'h17);
        stb_pulse(0, 8'h18);
        stb_pulse(0, 8'h19);
        check("pre_rst_ibf", ibf[0], 1'b1);
        check("pre_rst_intn", intn, 1'b0);
        tick;
        rstn = 1'b0;
        tick;
        rstn = 1'b1;
        check("mrst_ibf", ibf, 2'b00);
        check("mrst_intn", intn, 1'b1);
        check("mrst_oe", port_oe, 16'h0000);
        cpu_rd(4'h3, r); check("mrst_stat", r, 8'h01);
        cpu_rd(4'h2, r); check("mrst_ctrl", r, 8'h00);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
